// File: rtl/glitc_align_ctrl.sv
// ---------------------------------------------------------------------------
// glitc_align_ctrl
//
// Automatic bit-alignment trainer for one GLITC input data path. While the
// remote end transmits a fixed training pattern, this block sweeps the shared
// P/N IDELAY tap from 0 to 31 and grades each tap by watching the 4-bit
// deserialized word. It then picks the widest run of good taps (earliest run
// wins a tie), loads the centre of that run and issues bitslips until the word
// equals the training pattern. Once locked it counts pattern mismatches.
//
// Ports
//   clk_i         control clock, all logic runs on it
//   rst_n_i       asynchronous active-low reset
//   start_i       begin training (level, sampled when not busy)
//   data_i[3:0]   deserialized word, valid every cycle
//   delay_o[4:0]  IDELAY tap value
//   load_o        one-cycle IDELAY load strobe
//   bitslip_o     one-cycle bitslip strobe
//   busy_o        training in progress
//   locked_o      aligned; cleared only by start_i or reset
//   fail_o        training failed
//   eye_start_o   first tap of the chosen eye
//   eye_width_o   chosen eye width in taps (0..32)
//   err_count_o   mismatches since lock, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module glitc_align_ctrl #(
    parameter logic [3:0] TRAIN_PATTERN = 4'b0011,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         CHECK_CYCLES  = 64,
    parameter int         MIN_EYE       = 3,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [3:0]  data_i,
    output logic [4:0]  delay_o,
    output logic        load_o,
    output logic        bitslip_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic        fail_o,
    output logic [4:0]  eye_start_o,
    output logic [5:0]  eye_width_o,
    output logic [15:0] err_count_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_CENTER,
        S_CSETTLE, S_SCHECK, S_SLIP, S_SSETTLE, S_LOCKED, S_FAIL
    } state_t;

    localparam logic [3:0] ROT1        = {TRAIN_PATTERN[2:0], TRAIN_PATTERN[3]};
    localparam logic [3:0] ROT2        = {TRAIN_PATTERN[1:0], TRAIN_PATTERN[3:2]};
    localparam logic [3:0] ROT3        = {TRAIN_PATTERN[0], TRAIN_PATTERN[3:1]};
    localparam logic [6:0] SETTLE_LAST = 7'(SETTLE_CYCLES - 1);
    localparam logic [6:0] CHECK_LAST  = 7'(CHECK_CYCLES - 1);
    localparam logic [5:0] MIN_EYE_W   = 6'(MIN_EYE);
    localparam logic [3:0] MAX_SLIPS_W = 4'(MAX_SLIPS);

    state_t      state_q, state_d;
    logic [4:0]  tap_q, tap_d;
    logic [4:0]  delay_q, delay_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [3:0]  ref_q, ref_d;
    logic        good_q, good_d;
    logic [5:0]  run_len_q, run_len_d;
    logic [4:0]  run_start_q, run_start_d;
    logic [5:0]  best_len_q, best_len_d;
    logic [4:0]  best_start_q, best_start_d;
    logic [3:0]  slips_q, slips_d;
    logic [4:0]  eye_start_q, eye_start_d;
    logic [5:0]  eye_width_q, eye_width_d;
    logic [15:0] err_q, err_d;
    logic [4:0]  centre;
    logic        is_rotation;

    // A tap can only be good if the word it produces is some rotation of the
    // pattern; any rotation can later be corrected by bitslips.
    assign is_rotation = (data_i == TRAIN_PATTERN) || (data_i == ROT1) ||
                         (data_i == ROT2) || (data_i == ROT3);

    // Next-state and strobe decode. The tap value is written into delay_q on
    // the transition into LOAD/CENTER so that delay_o is already stable in the
    // cycle load_o is high. Run and best trackers are folded together in NEXT
    // so the end-of-sweep decision sees the result of the last tap.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        delay_d      = delay_q;
        cnt_d        = cnt_q;
        ref_d        = ref_q;
        good_d       = good_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        slips_d      = slips_q;
        eye_start_d  = eye_start_q;
        eye_width_d  = eye_width_q;
        err_d        = err_q;
        centre       = 5'd0;
        load_o       = 1'b0;
        bitslip_o    = 1'b0;
        busy_o       = 1'b1;
        locked_o     = 1'b0;
        fail_o       = 1'b0;

        case (state_q)
            S_IDLE, S_LOCKED, S_FAIL: begin
                busy_o   = 1'b0;
                locked_o = (state_q == S_LOCKED);
                fail_o   = (state_q == S_FAIL);
                if (state_q == S_LOCKED && data_i != TRAIN_PATTERN && err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
                if (start_i) begin
                    state_d      = S_LOAD;
                    tap_d        = 5'd0;
                    delay_d      = 5'd0;
                    cnt_d        = 7'd0;
                    good_d       = 1'b0;
                    run_len_d    = 6'd0;
                    run_start_d  = 5'd0;
                    best_len_d   = 6'd0;
                    best_start_d = 5'd0;
                    slips_d      = 4'd0;
                    eye_start_d  = 5'd0;
                    eye_width_d  = 6'd0;
                    err_d        = 16'd0;
                end
            end
            S_LOAD: begin
                load_o  = 1'b1;
                cnt_d   = 7'd0;
                state_d = S_SETTLE;
            end
            S_SETTLE, S_CSETTLE, S_SSETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = (state_q == S_SETTLE) ? S_CHECK : S_SCHECK;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_CHECK: begin
                // First sample becomes the reference; later samples must match it.
                if (cnt_q == 7'd0) begin
                    ref_d  = data_i;
                    good_d = is_rotation;
                end else if (data_i != ref_q) begin
                    good_d = 1'b0;
                end
                if (cnt_q == CHECK_LAST) begin
                    cnt_d   = 7'd0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_NEXT: begin
                if (good_q) begin
                    run_len_d = run_len_q + 6'd1;
                    if (run_len_q == 6'd0) begin
                        run_start_d = tap_q;
                    end
                end else begin
                    run_len_d = 6'd0;
                end
                // Strict compare keeps the earliest eye on a tie.
                if (run_len_d > best_len_q) begin
                    best_len_d   = run_len_d;
                    best_start_d = run_start_d;
                end
                centre = best_start_d + 5'((best_len_d - 6'd1) >> 1);
                if (tap_q == 5'd31) begin
                    if (best_len_d >= MIN_EYE_W) begin
                        delay_d = centre;
                        state_d = S_CENTER;
                    end else begin
                        eye_start_d = best_start_d;
                        eye_width_d = best_len_d;
                        state_d     = S_FAIL;
                    end
                end else begin
                    tap_d   = tap_q + 5'd1;
                    delay_d = tap_q + 5'd1;
                    state_d = S_LOAD;
                end
            end
            S_CENTER: begin
                load_o      = 1'b1;
                eye_start_d = best_start_q;
                eye_width_d = best_len_q;
                cnt_d       = 7'd0;
                state_d     = S_CSETTLE;
            end
            S_SCHECK: begin
                if (data_i == TRAIN_PATTERN) begin
                    state_d = S_LOCKED;
                end else if (slips_q == MAX_SLIPS_W) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_SLIP;
                end
            end
            S_SLIP: begin
                bitslip_o = 1'b1;
                slips_d   = slips_q + 4'd1;
                cnt_d     = 7'd0;
                state_d   = S_SSETTLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial training result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            tap_q        <= 5'd0;
            delay_q      <= 5'd0;
            cnt_q        <= 7'd0;
            ref_q        <= 4'd0;
            good_q       <= 1'b0;
            run_len_q    <= 6'd0;
            run_start_q  <= 5'd0;
            best_len_q   <= 6'd0;
            best_start_q <= 5'd0;
            slips_q      <= 4'd0;
            eye_start_q  <= 5'd0;
            eye_width_q  <= 6'd0;
            err_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            delay_q      <= delay_d;
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            good_q       <= good_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            slips_q      <= slips_d;
            eye_start_q  <= eye_start_d;
            eye_width_q  <= eye_width_d;
            err_q        <= err_d;
        end
    end

    assign delay_o     = delay_q;
    assign eye_start_o = eye_start_q;
    assign eye_width_o = eye_width_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_glitc_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_glitc_align_ctrl
//
// Bench for glitc_align_ctrl. A channel process models the IDELAY/ISERDES path:
// the tap latched on each load pulse selects clean or random data, clean data is
// the base word rotated left once per effective bitslip. A behavioural model
// derives expected eye/centre/slip results from the good-tap mask directly.
// ---------------------------------------------------------------------------
module tb_glitc_align_ctrl;

    localparam logic [3:0] PAT       = 4'b0011;
    localparam int         SETTLE    = 16;
    localparam int         MIN_EYE   = 3;
    localparam int         MAX_SLIPS = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  data_i;
    logic [4:0]  delay_o;
    logic        load_o;
    logic        bitslip_o;
    logic        busy_o;
    logic        locked_o;
    logic        fail_o;
    logic [4:0]  eye_start_o;
    logic [5:0]  eye_width_o;
    logic [15:0] err_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    // channel state
    logic [31:0] good_mask = 32'd0;
    logic [3:0]  base_word = PAT;
    bit          slip_works = 1'b1;
    bit          force_bad = 1'b0;
    int          ch_tap = 0;
    int          ch_slips = 0;
    int          load_cnt = 0;
    int          slip_cnt = 0;
    int          both_cnt = 0;
    int          gap_viol = 0;
    int          cyc = 0;
    int          last_pulse = -1000;
    logic [4:0]  first_load_delay = 5'd0;

    glitc_align_ctrl dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .data_i      (data_i),
        .delay_o     (delay_o),
        .load_o      (load_o),
        .bitslip_o   (bitslip_o),
        .busy_o      (busy_o),
        .locked_o    (locked_o),
        .fail_o      (fail_o),
        .eye_start_o (eye_start_o),
        .eye_width_o (eye_width_o),
        .err_count_o (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
        logic [3:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    function automatic logic [31:0] mask_range(input int lo, input int hi);
        logic [31:0] m;
        m = 32'd0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    // Reference: widest all-good interval (longest first, earliest start wins),
    // centre by floor, then the smallest slip count that yields the pattern.
    task automatic model(input logic [31:0] mask, input logic [3:0] base, input bit sw,
                         output bit lock, output int es, output int ew, output int ed,
                         output int ns, output int nl);
        bit all;
        es = 0; ew = 0; lock = 0; ns = 0;
        for (int l = 32; l >= 1 && ew == 0; l--) begin
            for (int s = 0; s + l <= 32 && ew == 0; s++) begin
                all = 1'b1;
                for (int t = s; t < s + l; t++) if (!mask[t]) all = 1'b0;
                if (all) begin es = s; ew = l; end
            end
        end
        if (ew < MIN_EYE) begin
            ed = 31; nl = 32;
        end else begin
            ed = es + (ew - 1) / 2; nl = 33; ns = MAX_SLIPS;
            for (int k = 0; k <= MAX_SLIPS; k++) begin
                if (rotl(base, sw ? k : 0) == PAT) begin lock = 1'b1; ns = k; break; end
            end
        end
    endtask

    // Channel: reacts to strobes seen this cycle, then drives the word.
    initial begin : channel
        logic [3:0] w;
        data_i = 4'd0;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (load_o || bitslip_o) begin
                if (load_o && bitslip_o) both_cnt++;
                if (cyc - last_pulse <= SETTLE) gap_viol++;
                last_pulse = cyc;
            end
            if (load_o) begin
                ch_tap = int'(delay_o);
                load_cnt++;
                if (load_cnt == 1) first_load_delay = delay_o;
            end
            if (bitslip_o) begin
                slip_cnt++;
                if (slip_works) ch_slips++;
            end
            if (force_bad) begin
                w = 4'($urandom);
                if (w == PAT) w = ~PAT;
                data_i = w;
            end else if (!good_mask[ch_tap]) begin
                data_i = 4'($urandom);
            end else begin
                data_i = rotl(base_word, ch_slips % 4);
            end
        end
    end

    task automatic set_channel(input logic [31:0] m, input logic [3:0] b, input bit sw);
        good_mask = m; base_word = b; slip_works = sw; force_bad = 1'b0;
    endtask

    task automatic start_training();
        @(negedge clk_i);
        load_cnt = 0; slip_cnt = 0; ch_tap = 0; ch_slips = 0; last_pulse = -1000;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({delay_o, load_o, bitslip_o, busy_o, locked_o, fail_o, eye_start_o, eye_width_o, err_count_o} !== 37'd0) begin
            n_bad++; $display("[TB] FAIL reset_outputs got %h want 0", {delay_o, load_o, bitslip_o, busy_o, locked_o, fail_o, eye_start_o, eye_width_o, err_count_o});
        end
        n_cmp++;
        if (load_cnt != 0) begin n_bad++; $display("[TB] FAIL reset_no_load got %0d want 0", load_cnt); end
        rst_n_i = 1'b1;
        repeat (5) @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0 || load_cnt != 0) begin
            n_bad++; $display("[TB] FAIL idle_after_reset got busy=%b loads=%0d want 0/0", busy_o, load_cnt);
        end
    endtask

    task automatic test_eye_center();
        bit ok;
        $display("[TB] eye 10..18, word 0110, start pulsed while busy");
        set_channel(mask_range(10, 18), 4'b0110, 1'b1);
        start_training();
        repeat (200) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL t1_done got timeout want done"); end
        n_cmp++; if (locked_o !== 1'b1 || fail_o !== 1'b0) begin n_bad++; $display("[TB] FAIL t1_lock got locked=%b fail=%b want 1/0", locked_o, fail_o); end
        n_cmp++; if (delay_o !== 5'd14) begin n_bad++; $display("[TB] FAIL t1_delay got %0d want 14", delay_o); end
        n_cmp++; if (eye_start_o !== 5'd10 || eye_width_o !== 6'd9) begin n_bad++; $display("[TB] FAIL t1_eye got %0d/%0d want 10/9", eye_start_o, eye_width_o); end
        n_cmp++; if (slip_cnt != 3) begin n_bad++; $display("[TB] FAIL t1_slips got %0d want 3", slip_cnt); end
        n_cmp++; if (load_cnt != 33) begin n_bad++; $display("[TB] FAIL t1_loads got %0d want 33", load_cnt); end
        n_cmp++; if (err_count_o !== 16'd0) begin n_bad++; $display("[TB] FAIL t1_err got %0d want 0", err_count_o); end
    endtask

    task automatic test_two_eyes();
        bit ok;
        $display("[TB] two eyes: widest wins, then tie keeps earliest");
        set_channel(mask_range(2, 5) | mask_range(20, 27), PAT, 1'b1);
        start_training();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL t2a_done got timeout want done"); end
        n_cmp++; if (eye_start_o !== 5'd20 || eye_width_o !== 6'd8 || delay_o !== 5'd23) begin
            n_bad++; $display("[TB] FAIL t2a_eye got %0d/%0d/%0d want 20/8/23", eye_start_o, eye_width_o, delay_o); end
        n_cmp++; if (locked_o !== 1'b1 || slip_cnt != 0) begin n_bad++; $display("[TB] FAIL t2a_lock got %b/%0d want 1/0", locked_o, slip_cnt); end
        set_channel(mask_range(3, 6) | mask_range(12, 15), 4'b1001, 1'b1);
        start_training();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL t2b_done got timeout want done"); end
        n_cmp++; if (eye_start_o !== 5'd3 || eye_width_o !== 6'd4 || delay_o !== 5'd4) begin
            n_bad++; $display("[TB] FAIL t2b_eye got %0d/%0d/%0d want 3/4/4", eye_start_o, eye_width_o, delay_o); end
        n_cmp++; if (locked_o !== 1'b1 || slip_cnt != 1) begin n_bad++; $display("[TB] FAIL t2b_lock got %b/%0d want 1/1", locked_o, slip_cnt); end
    endtask

    task automatic test_no_eye();
        bit ok;
        $display("[TB] no good tap, then eye narrower than minimum");
        set_channel(32'd0, PAT, 1'b1);
        start_training();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL t3a_done got timeout want done"); end
        n_cmp++; if (fail_o !== 1'b1 || locked_o !== 1'b0) begin n_bad++; $display("[TB] FAIL t3a_fail got fail=%b locked=%b want 1/0", fail_o, locked_o); end
        n_cmp++; if (load_cnt != 32 || delay_o !== 5'd31 || eye_width_o !== 6'd0) begin
            n_bad++; $display("[TB] FAIL t3a_sweep got loads=%0d delay=%0d width=%0d want 32/31/0", load_cnt, delay_o, eye_width_o); end
        set_channel(mask_range(5, 6), PAT, 1'b1);
        start_training();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL t3b_done got timeout want done"); end
        n_cmp++; if (fail_o !== 1'b1 || eye_start_o !== 5'd5 || eye_width_o !== 6'd2 || delay_o !== 5'd31) begin
            n_bad++; $display("[TB] FAIL t3b_narrow got fail=%b eye=%0d/%0d delay=%0d want 1 5/2 31", fail_o, eye_start_o, eye_width_o, delay_o); end
    endtask

    task automatic test_slip_limit();
        bit ok;
        $display("[TB] full-width eye, bitslip ineffective");
        set_channel(32'hFFFF_FFFF, 4'b0110, 1'b0);
        start_training();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL t4_done got timeout want done"); end
        n_cmp++; if (slip_cnt != MAX_SLIPS) begin n_bad++; $display("[TB] FAIL t4_slips got %0d want %0d", slip_cnt, MAX_SLIPS); end
        n_cmp++; if (fail_o !== 1'b1 || locked_o !== 1'b0) begin n_bad++; $display("[TB] FAIL t4_fail got fail=%b locked=%b want 1/0", fail_o, locked_o); end
        n_cmp++; if (eye_start_o !== 5'd0 || eye_width_o !== 6'd32 || delay_o !== 5'd15) begin
            n_bad++; $display("[TB] FAIL t4_eye got %0d/%0d/%0d want 0/32/15", eye_start_o, eye_width_o, delay_o); end
    endtask

    task automatic test_abort_restart();
        bit seen;
        int loads_snap;
        $display("[TB] reset at tap 7, then restart");
        set_channel(32'hFFFF_FFFF, PAT, 1'b1);
        start_training();
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            if (load_cnt >= 8) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("[TB] FAIL t6_reach_tap7 got timeout want tap 7"); end
        repeat (5) @(negedge clk_i);
        n_cmp++; if (delay_o !== 5'd7 || busy_o !== 1'b1) begin n_bad++; $display("[TB] FAIL t6_tap7 got %0d/%b want 7/1", delay_o, busy_o); end
        rst_n_i = 1'b0;
        #1;
        n_cmp++;
        if ({delay_o, load_o, bitslip_o, busy_o, locked_o, fail_o, eye_start_o, eye_width_o, err_count_o} !== 37'd0) begin
            n_bad++; $display("[TB] FAIL t6_abort_outputs got %h want 0", {delay_o, load_o, bitslip_o, busy_o, locked_o, fail_o, eye_start_o, eye_width_o, err_count_o});
        end
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        loads_snap = load_cnt;
        repeat (10) @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0 || load_cnt != loads_snap) begin
            n_bad++; $display("[TB] FAIL t6_idle got busy=%b loads=%0d want 0/%0d", busy_o, load_cnt, loads_snap); end
        start_training();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (load_cnt >= 1) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen || first_load_delay !== 5'd0) begin
            n_bad++; $display("[TB] FAIL t6_restart got seen=%b delay=%0d want 1/0", seen, first_load_delay); end
        @(negedge clk_i);
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_lock_errors();
        bit ok, lock;
        int s, l, es, ew, ed, ns, nl;
        logic [3:0] base;
        s = $urandom_range(0, 25);
        l = $urandom_range(3, 32 - s);
        base = rotl(PAT, $urandom_range(0, 3));
        $display("[TB] random eye start %0d width %0d word %b", s, l, base);
        set_channel(mask_range(s, s + l - 1), base, 1'b1);
        model(mask_range(s, s + l - 1), base, 1'b1, lock, es, ew, ed, ns, nl);
        start_training();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("[TB] FAIL t5_done got timeout want done"); end
        n_cmp++; if (locked_o !== lock || fail_o !== !lock) begin n_bad++; $display("[TB] FAIL t5_lock got %b/%b want %b", locked_o, fail_o, lock); end
        n_cmp++; if (eye_start_o !== 5'(es) || eye_width_o !== 6'(ew) || delay_o !== 5'(ed)) begin
            n_bad++; $display("[TB] FAIL t5_eye got %0d/%0d/%0d want %0d/%0d/%0d", eye_start_o, eye_width_o, delay_o, es, ew, ed); end
        n_cmp++; if (slip_cnt != ns || load_cnt != nl) begin
            n_bad++; $display("[TB] FAIL t5_pulses got slips=%0d loads=%0d want %0d/%0d", slip_cnt, load_cnt, ns, nl); end
        repeat (20) @(negedge clk_i);
        n_cmp++; if (err_count_o !== 16'd0) begin n_bad++; $display("[TB] FAIL t5_err_clean got %0d want 0", err_count_o); end
        force_bad = 1'b1;
        repeat (5) @(negedge clk_i);
        force_bad = 1'b0;
        repeat (5) @(negedge clk_i);
        n_cmp++; if (err_count_o !== 16'd5) begin n_bad++; $display("[TB] FAIL t5_err5 got %0d want 5", err_count_o); end
        force_bad = 1'b1;
        repeat (65535) @(negedge clk_i);
        n_cmp++; if (err_count_o !== 16'hFFFF) begin n_bad++; $display("[TB] FAIL t5_sat got %h want ffff", err_count_o); end
        repeat (5) @(negedge clk_i);
        force_bad = 1'b0;
        n_cmp++; if (err_count_o !== 16'hFFFF || locked_o !== 1'b1) begin
            n_bad++; $display("[TB] FAIL t5_sat_hold got %h/%b want ffff/1", err_count_o, locked_o); end
    endtask

    task automatic test_pulse_rules();
        n_cmp++; if (both_cnt != 0) begin n_bad++; $display("[TB] FAIL pulse_overlap got %0d want 0", both_cnt); end
        n_cmp++; if (gap_viol != 0) begin n_bad++; $display("[TB] FAIL pulse_spacing got %0d want 0", gap_viol); end
    endtask

    initial begin
        test_reset();
        test_eye_center();
        test_two_eyes();
        test_no_eye();
        test_slip_limit();
        test_abort_restart();
        test_lock_errors();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
